// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared defaults and constants for the instruction fetch unit and its FIFO.
//   No ports; import with `import instruction_fetch_unit_pkg::*;`.
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  localparam int          ADDR_W_DEFAULT   = 32;
  localparam int          INSTR_W_DEFAULT  = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          DEPTH_DEFAULT    = 2;

  // Byte distance between consecutive instruction words.
  localparam int          PC_INC           = 4;

endpackage : instruction_fetch_unit_pkg

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundles the instruction-memory read port and the decode valid/ready
//   handshake of the fetch unit.
//   master : fetch unit side   (drives imem_a, instr_valid, instr, instr_pc)
//   slave  : memory/decode side (drives imem_rd, instr_ready)
//   imem_a      ADDR_W   byte address to instruction memory (word aligned)
//   imem_rd     INSTR_W  combinational read data for imem_a
//   instr_valid 1        head of fetch queue is valid
//   instr_ready 1        decode accepts the head this cycle
//   instr       INSTR_W  head instruction word (0 when empty)
//   instr_pc    ADDR_W   PC of the head word (0 when empty)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic [ADDR_W-1:0]  imem_a;
  logic [INSTR_W-1:0] imem_rd;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output imem_a,
    input  imem_rd,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_a,
    output imem_rd,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface : instruction_fetch_unit_if

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO holding {pc, instruction} pairs between fetch and
//   decode. Registered storage, head read combinationally (dout = mem[rd_ptr]).
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low
//   flush  in   synchronous clear of pointers and count; a push is dropped
//   push   in   write din at wr_ptr
//   din    in   W-bit entry
//   pop    in   advance rd_ptr
//   dout   out  entry at rd_ptr
//   count  out  occupancy, log2(DEPTH)+1 bits
//   empty  out  count == 0
//   full   out  count == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers are exactly log2(DEPTH) bits, so DEPTH being a power of two
  // makes them wrap without any compare.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate every read, so
  // stale contents are never observable and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // The producer only pushes into a full queue when the head leaves the same
  // cycle, and the consumer only pops a non-empty queue.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule : fetch_fifo

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Initiator of the instruction-memory read port. Owns the PC, fetches one
//   word per cycle into fetch_fifo and presents the queue head to decode with
//   a valid/ready handshake. A redirect reloads the PC and flushes the queue;
//   halt stops new fetches while the queue drains.
//   clk             in   rising-edge clock
//   rst_n           in   synchronous reset, active low
//   halt            in   suppress new fetches
//   redirect_valid  in   load redirect_pc and flush the queue
//   redirect_pc     in   new PC, bits [1:0] ignored
//   bus             master modport: imem_a/imem_rd, instr_valid/instr_ready,
//                   instr, instr_pc
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                INSTR_W  = INSTR_W_DEFAULT,
  parameter int                DEPTH    = DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    halt,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  instruction_fetch_unit_if.master bus
);

  localparam int W     = ADDR_W + INSTR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic [W-1:0]      fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  // A full queue may still accept a word when the head leaves this cycle,
  // which keeps one fetch per cycle at full throughput.
  assign pop  = bus.instr_valid & bus.instr_ready;
  assign push = !halt & !redirect_valid & (!fifo_full | pop);

  // Redirect outranks fetch; the PC wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~ADDR_W'(3);
    end else if (push) begin
      pc <= pc + ADDR_W'(PC_INC);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .din   ({pc, bus.imem_rd}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.imem_a      = pc;
  assign bus.instr_valid = !fifo_empty;
  // Head fields read as zero while empty so decode never sees stale data.
  assign bus.instr       = fifo_empty ? '0 : fifo_dout[INSTR_W-1:0];
  assign bus.instr_pc    = fifo_empty ? '0 : fifo_dout[W-1:INSTR_W];

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(DEPTH));

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus    ();
  instruction_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus_hi ();

  // Instruction memory model: word at byte address 4*i is A000_0000 + i.
  assign bus.imem_rd    = 32'hA000_0000 + {2'b00, bus.imem_a[31:2]};
  assign bus_hi.imem_rd = 32'hA000_0000 + {2'b00, bus_hi.imem_a[31:2]};
  assign bus_hi.instr_ready = 1'b1;

  instruction_fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(2), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  instruction_fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)
  ) dut_hi (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus_hi)
  );

  typedef struct {
    logic        ready;
    logic        halt;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_a;
  } vec_t;

  localparam int N_VEC = 25;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [31:0] a);
    check({tag, " valid"},    {31'b0, bus.instr_valid}, {31'b0, v});
    check({tag, " instr"},    bus.instr,    ins);
    check({tag, " instr_pc"}, bus.instr_pc, pc);
    check({tag, " imem_a"},   bus.imem_a,   a);
  endtask

  task automatic check_hi(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] pc, input logic [31:0] a);
    check({tag, " hi valid"},    {31'b0, bus_hi.instr_valid}, {31'b0, v});
    check({tag, " hi instr"},    bus_hi.instr,    ins);
    check({tag, " hi instr_pc"}, bus_hi.instr_pc, pc);
    check({tag, " hi imem_a"},   bus_hi.imem_a,   a);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_next;
    logic [31:0] a_before;
    logic        was_redir;
    logic        was_halt;

    // Each row: inputs for one edge, then outputs expected just after it.
    //          rdy  halt redir redir_pc       valid instr          pc             imem_a
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0001, 32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h0000_0008, 32'h0000_000C};
    // decode stalls five cycles: queue fills, PC stops, head holds
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h0000_0008, 32'h0000_0010};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h0000_0008, 32'h0000_0010};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h0000_0008, 32'h0000_0010};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h0000_0008, 32'h0000_0010};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 32'h0000_0008, 32'h0000_0010};
    // release: pop and push on a full queue
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0003, 32'h0000_000C, 32'h0000_0014};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0004, 32'h0000_0010, 32'h0000_0018};
    // redirect with a full queue, low address bits dropped
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         32'h0,         32'h0000_0100};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0040, 32'h0000_0100, 32'h0000_0104};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0040, 32'h0000_0100, 32'h0000_0108};
    // halt with two queued: drain, PC frozen
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0041, 32'h0000_0104, 32'h0000_0108};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0,         32'h0000_0108};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0,         32'h0000_0108};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0042, 32'h0000_0108, 32'h0000_010C};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0043, 32'h0000_010C, 32'h0000_0110};
    // redirect while halted still moves the PC
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h0000_0207, 1'b0, 32'h0,         32'h0,         32'h0000_0204};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0,         32'h0000_0204};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0081, 32'h0000_0204, 32'h0000_0208};
    // PC wrap through the top of the address space
    vecs[21] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFF8};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDFFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 32'h0000_0000, 32'h0000_0004};

    // Reset
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.instr_ready = 1'b0;
    step();
    step();
    check_main("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    check_hi("reset", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF8);

    rst_n = 1'b1;
    for (int i = 0; i < N_VEC; i++) begin
      bus.instr_ready = vecs[i].ready;
      halt            = vecs[i].halt;
      redirect_valid  = vecs[i].redir;
      redirect_pc     = vecs[i].redir_pc;
      step();
      check_main($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_instr,
                 vecs[i].exp_pc, vecs[i].exp_a);
    end
    halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Fill the queue, then reset mid-stream with a redirect also asserted.
    bus.instr_ready = 1'b0;
    step();
    check_main("fill1", 1'b1, 32'hA000_0000, 32'h0, 32'h8);
    step();
    check_main("fill2", 1'b1, 32'hA000_0000, 32'h0, 32'h8);
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    step();
    check_main("midrst", 1'b0, 32'h0, 32'h0, 32'h0);
    check_hi("midrst", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF8);

    rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; bus.instr_ready = 1'b1;
    step();
    check_main("post0", 1'b1, 32'hA000_0000, 32'h0, 32'h4);
    check_hi("post0", 1'b1, 32'hDFFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    step();
    check_main("post1", 1'b1, 32'hA000_0001, 32'h4, 32'h8);
    check_hi("post1", 1'b1, 32'hDFFF_FFFF, 32'hFFFF_FFFC, 32'h0);
    step();
    check_main("post2", 1'b1, 32'hA000_0002, 32'h8, 32'hC);
    check_hi("post2", 1'b1, 32'hA000_0000, 32'h0, 32'h4);

    // Soak: random ready/halt/redirect; every accepted word must continue the
    // expected address stream and carry the memory word for its PC.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; bus.instr_ready = 1'b0;
    step();
    exp_next = 32'h0000_0040;
    redirect_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      halt            = ($urandom_range(0, 7) == 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_pc     = {22'b0, 10'($urandom_range(0, 1023))};
      if (bus.instr_valid && bus.instr_ready) begin
        check($sformatf("soak%0d pc", c), bus.instr_pc, exp_next);
        check($sformatf("soak%0d instr", c), bus.instr,
              32'hA000_0000 + {2'b00, exp_next[31:2]});
        exp_next = exp_next + 32'd4;
      end
      if (redirect_valid) exp_next = redirect_pc & ~32'd3;
      a_before  = bus.imem_a;
      was_redir = redirect_valid;
      was_halt  = halt;
      step();
      if (was_redir) begin
        check($sformatf("soak%0d flush", c), {31'b0, bus.instr_valid}, 32'h0);
        check($sformatf("soak%0d redir_a", c), bus.imem_a, exp_next);
      end else if (was_halt) begin
        check($sformatf("soak%0d halt_a", c), bus.imem_a, a_before);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_instruction_fetch_unit
